// File: rtl/modem_symbol_packer_if.sv
// Handshake bundle between the bit-stream source, the symbol packer and the
// constellation mapper. The slave modport is the packer side; the master
// modport is whoever drives the words in and takes the symbols out.
interface modem_symbol_packer_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_SYM_W = 4
);
  logic                 i_valid;
  logic [DATA_W-1:0]    i_data;
  logic                 o_ready;
  logic                 o_valid;
  logic [MAX_SYM_W-1:0] o_sym;
  logic                 i_ready;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sym
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sym
  );
endinterface

// File: rtl/modem_symbol_packer.sv
// Byte-to-symbol packer for the modem TX path (framer/scrambler -> mapper).
// Bits are kept MSB-aligned in a shift buffer of DATA_W+MAX_SYM_W-1 bits;
// everything below the fill level is always zero, so appending is a plain OR
// and flush padding comes for free. Residual bits carry across input words.
// Optional macro MODEM_PACKER_FLUSH_EN adds i_flush, which zero-pads a
// partial trailing symbol so it can be emitted.
module modem_symbol_packer #(
  parameter int DATA_W    = 8,
  parameter int MAX_SYM_W = 4
) (
  input  logic                  iclk,
  input  logic                  ireset,
  input  logic [1:0]            i_mode,
`ifdef MODEM_PACKER_FLUSH_EN
  input  logic                  i_flush,
`endif
  modem_symbol_packer_if.slave  bus,
  output logic                  o_busy
);

  localparam int BUF_W  = DATA_W + MAX_SYM_W - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]     r_buf;
  logic [FILL_W-1:0]    r_fill;
  logic [1:0]           r_mode;

  logic [FILL_W-1:0]    w_sym_w;
  logic [FILL_W-1:0]    w_fill_after;
  logic [FILL_W-1:0]    w_fill_nxt;
  logic [BUF_W-1:0]     w_shifted;
  logic [BUF_W-1:0]     w_in_word;
  logic [BUF_W-1:0]     w_buf_nxt;
  logic [MAX_SYM_W-1:0] w_top;
  logic                 w_room;
  logic                 w_flush_req;
  logic                 w_do_flush;
  logic                 w_o_ready;
  logic                 w_o_valid;
  logic                 w_in_xfer;
  logic                 w_out_xfer;

`ifdef MODEM_PACKER_FLUSH_EN
  assign w_flush_req = i_flush;
`else
  assign w_flush_req = 1'b0;
`endif

  // Handshake decode; every output here comes from registers (plus i_flush).
  always_comb begin
    w_sym_w    = FILL_W'(r_mode) + FILL_W'(1);
    w_room     = (r_fill <= FILL_W'(BUF_W - DATA_W));
    w_o_ready  = w_room && !w_flush_req;
    w_o_valid  = (r_fill >= w_sym_w);
    w_in_xfer  = bus.i_valid && w_o_ready;
    w_out_xfer = w_o_valid && bus.i_ready;
    w_do_flush = w_flush_req && (r_fill != '0) && (r_fill < w_sym_w);
    w_top      = r_buf[BUF_W-1 -: MAX_SYM_W];
  end

  assign bus.o_ready = w_o_ready;
  assign bus.o_valid = w_o_valid;
  assign bus.o_sym   = w_top >> (FILL_W'(MAX_SYM_W) - w_sym_w);
  assign o_busy      = (r_fill != '0);

  // Next buffer/fill: shift out first, then append the new word behind
  // whatever valid bits remain so bit order is preserved.
  always_comb begin
    w_shifted    = r_buf;
    w_fill_after = r_fill;
    if (w_out_xfer) begin
      w_shifted    = r_buf << w_sym_w;
      w_fill_after = r_fill - w_sym_w;
    end
    w_in_word  = BUF_W'(bus.i_data) << (BUF_W - DATA_W);
    w_buf_nxt  = w_shifted;
    w_fill_nxt = w_fill_after;
    if (w_in_xfer) begin
      w_buf_nxt  = w_shifted | (w_in_word >> w_fill_after);
      w_fill_nxt = w_fill_after + FILL_W'(DATA_W);
    end
    if (w_do_flush) begin
      w_fill_nxt = w_sym_w;
    end
  end

  // Buffer, fill level and latched mode; mode only moves while fully empty.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_mode <= 2'd0;
    end else begin
      r_buf  <= w_buf_nxt;
      r_fill <= w_fill_nxt;
      if ((r_fill == '0) && !w_in_xfer) begin
        r_mode <= i_mode;
      end
    end
  end

endmodule

// File: tb/tb_modem_symbol_packer.sv
// Directed bench for modem_symbol_packer: QPSK/PSK8/BPSK/QAM16 streams,
// backpressure, mode hold while bits are buffered, mid-stream reset and
// (with MODEM_PACKER_FLUSH_EN) residual flush.
module tb_modem_symbol_packer;

  logic       iclk;
  logic       ireset;
  logic [1:0] i_mode;
  logic       o_busy;
`ifdef MODEM_PACKER_FLUSH_EN
  logic       i_flush;
`endif

  modem_symbol_packer_if #(.DATA_W(8), .MAX_SYM_W(4)) bus ();

  modem_symbol_packer #(.DATA_W(8), .MAX_SYM_W(4)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .i_mode  (i_mode),
`ifdef MODEM_PACKER_FLUSH_EN
    .i_flush (i_flush),
`endif
    .bus     (bus),
    .o_busy  (o_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] got_q[$];

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Record every output transfer; sampled half a cycle before the edge.
  always @(negedge iclk) begin
    if (!ireset && bus.o_valid && bus.i_ready) got_q.push_back(bus.o_sym);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d);
    logic acc;
    bit   done;
    done = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge iclk);
      acc = bus.o_ready;
      step();
      if (acc) done = 1;
    end
    bus.i_valid = 1'b0;
    chk("send_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (!o_busy) done = 1;
      else step();
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  // exp holds n symbols as nibbles, first symbol in the most significant one.
  task automatic chk_syms(input string tag, input int n, input logic [63:0] exp);
    logic [3:0] e;
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = exp[(n-1-i)*4 +: 4];
      if (i < got_q.size()) chk(tag, {28'd0, got_q[i]}, {28'd0, e});
    end
  endtask

  initial begin
    logic [7:0] t3b;
    int idx;
    ireset      = 1'b1;
    i_mode      = 2'd0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_ready = 1'b1;
`ifdef MODEM_PACKER_FLUSH_EN
    i_flush     = 1'b0;
`endif
    #12;
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    chk("rst_busy",  {31'd0, o_busy},      32'd0);
    chk("rst_sym",   {28'd0, bus.o_sym},   32'd0);
    ireset = 1'b0;

    // 1: QPSK 0xB4 -> 2,3,1,0 on consecutive cycles
    i_mode = 2'd1;
    step(); step();
    got_q.delete();
    send(8'hB4);
    chk("t1_first_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("t1_first_sym",   {28'd0, bus.o_sym},   32'd2);
    repeat (4) step();
    chk("t1_busy", {31'd0, o_busy}, 32'd0);
    chk("t1_valid", {31'd0, bus.o_valid}, 32'd0);
    chk_syms("t1_sym", 4, 64'h2310);

    // 2: PSK8 0xFA,0x5C,0x3E -> 7,6,4,5,6,0,7,6
    i_mode = 2'd2;
    step(); step();
    got_q.delete();
    send(8'hFA);
    send(8'h5C);
    send(8'h3E);
    wait_idle();
    chk_syms("t2_sym", 8, 64'h76456076);
    chk("t2_busy", {31'd0, o_busy}, 32'd0);

    // 3: BPSK 0x81 under i_ready pattern 1,0,0,1,0,0,...
    i_mode = 2'd0;
    bus.i_ready = 1'b0;
    step(); step();
    got_q.delete();
    send(8'h81);
    t3b = 8'h81;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      bus.i_ready = (c % 3 == 0);
      #1;
      chk("t3_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("t3_sym", {28'd0, bus.o_sym}, {31'd0, t3b[7-idx]});
      step();
      if (bus.i_ready) idx++;
    end
    bus.i_ready = 1'b1;
    chk("t3_consumed", idx, 8);
    chk("t3_busy", {31'd0, o_busy}, 32'd0);
    chk_syms("t3_sym_seq", 8, 64'h10000001);

    // 4: PSK8 0xFF leaves 2 residual bits; mode change must wait for empty
    i_mode = 2'd2;
    step(); step();
    got_q.delete();
    send(8'hFF);
    step(); step();
    chk("t4_resid_busy",  {31'd0, o_busy},      32'd1);
    chk("t4_resid_valid", {31'd0, bus.o_valid}, 32'd0);
    i_mode = 2'd0;
    repeat (3) begin
      step();
      chk("t4_mode_held", {31'd0, bus.o_valid}, 32'd0);
    end
    send(8'h00);
    repeat (3) step();
    chk("t4_resid1_busy",  {31'd0, o_busy},      32'd1);
    chk("t4_resid1_valid", {31'd0, bus.o_valid}, 32'd0);
    send(8'hFF);
    wait_idle();
    chk_syms("t4_psk8_sym", 8, 64'h77600377);
    step();
    got_q.delete();
    send(8'hA5);
    wait_idle();
    chk_syms("t4_bpsk_sym", 8, 64'h10100101);

    // 5: QAM16 0xC3, reset after first symbol
    i_mode = 2'd3;
    step(); step();
    got_q.delete();
    send(8'hC3);
    chk("t5_first_sym", {28'd0, bus.o_sym}, 32'hC);
    step();
    ireset = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("t5_rst_busy",  {31'd0, o_busy},      32'd0);
    chk("t5_rst_sym",   {28'd0, bus.o_sym},   32'd0);
    chk("t5_rst_ready", {31'd0, bus.o_ready}, 32'd1);
    step();
    ireset = 1'b0;
    // word accepted on the first cycle after reset uses the reset mode (BPSK)
    send(8'h80);
    chk("t5_bpsk_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("t5_bpsk_sym",   {28'd0, bus.o_sym},   32'd1);
    wait_idle();
    chk_syms("t5_sym", 9, 64'hC10000000);

`ifdef MODEM_PACKER_FLUSH_EN
    // 6: PSK8 0xFF, drain 7,7, flush residual -> 6
    i_mode = 2'd2;
    step(); step();
    got_q.delete();
    send(8'hFF);
    step(); step();
    chk("t6_resid_valid", {31'd0, bus.o_valid}, 32'd0);
    i_flush = 1'b1;
    #1;
    chk("t6_flush_ready", {31'd0, bus.o_ready}, 32'd0);
    step();
    i_flush = 1'b0;
    chk("t6_flush_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("t6_flush_sym",   {28'd0, bus.o_sym},   32'd6);
    step();
    chk("t6_busy", {31'd0, o_busy}, 32'd0);
    chk_syms("t6_sym", 3, 64'h776);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
